hilo_div_ctrl: RTL and testbench

Issue/retire controller for the 32-bit sequential signed divider core, and owner of the architectural HI/LO registers. It sits between the EX stage and the divider core. It accepts a DIV request from EX, holds the operands stable for the full divide, and pulses the core's start. It stalls the pipeline while the core runs, then writes quotient to LO and remainder to HI. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

---
 rtl/hilo_pkg.sv | 30 +++
 rtl/hilo_regs.sv | 54 +++++
 rtl/hilo_div_ctrl.sv | 124 ++++++++++++
 tb/tb_hilo_div_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Purpose  : Shared types and defaults for the HI/LO divide controller.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  localparam int          DIV_CYCLES_DEFAULT = 32;
  localparam int          TIMEOUT_DEFAULT    = 40;
  localparam logic [31:0] DIV_BY_ZERO_LO     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    SETTLE    = 3'd4,
    CAPTURE   = 3'd5
  } div_state_t;

  typedef enum logic [1:0] {
    WR_NONE    = 2'd0,
    WR_MT      = 2'd1,
    WR_CAPTURE = 2'd2,
    WR_DIV0    = 2'd3
  } hilo_wsel_t;

endpackage
`default_nettype wire

// File: rtl/hilo_regs.sv
`default_nettype none
// ============================================================================
// Module   : hilo_regs
// Purpose  : Architectural HI/LO register pair with its write-source mux.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_regs
  import hilo_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  wsel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic [31:0] cap_q,
  input  logic [31:0] cap_r,
  input  logic [31:0] dz_dividend,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      case (wsel)
        WR_MT: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
        end
        WR_CAPTURE: begin
          r_hi <= cap_r;
          r_lo <= cap_q;
        end
        // Divide by zero: remainder is the dividend, quotient all ones.
        WR_DIV0: begin
          r_hi <= dz_dividend;
          r_lo <= DIV_BY_ZERO_LO;
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_div_ctrl
// Purpose  : Issue/retire control for the sequential divider; owns HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        div_err,
  output logic        div_start,
  output logic        div_rst,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int                  c_tcnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_tcnt_w-1:0] c_tmax   = c_tcnt_w'(TIMEOUT - 1);

  if (TIMEOUT <= DIV_CYCLES + 4) begin : g_timeout_too_short
    $error("TIMEOUT must exceed the full divide latency");
  end

  div_state_t          r_state;
  div_state_t          w_next_state;
  logic [c_tcnt_w-1:0] r_tcnt;
  logic                r_err;
  logic [31:0]         r_dividend;
  logic [31:0]         r_divisor;
  logic                w_accept;
  logic                w_timeout;
  hilo_wsel_t          w_wsel;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) r_tcnt <= '0;
      else                 r_tcnt <= r_tcnt + 1'b1;
      if (w_timeout) r_err <= 1'b1;
      // Operands stay frozen until the next accept; the core reads signs live.
      if (w_accept) begin
        r_dividend <= op_a;
        r_divisor  <= op_b;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_wsel       = WR_NONE;
    w_accept     = 1'b0;
    w_timeout    = (r_state != IDLE) && (r_state != CAPTURE) && (r_tcnt == c_tmax);
    case (r_state)
      IDLE: begin
        if (div_req) begin
          if (op_b != '0) begin
            w_accept     = 1'b1;
            w_next_state = START;
          end else begin
            w_wsel = WR_DIV0;
          end
        end else if (hi_we || lo_we) begin
          w_wsel = WR_MT;
        end
      end
      START:     w_next_state = WAIT_BUSY;
      WAIT_BUSY: if (div_busy)  w_next_state = RUN;
      RUN:       if (!div_busy) w_next_state = SETTLE;
      SETTLE:    w_next_state = CAPTURE;
      CAPTURE: begin
        w_wsel       = WR_CAPTURE;
        w_next_state = IDLE;
      end
      default:   w_next_state = IDLE;
    endcase
    if (w_timeout) w_next_state = IDLE;
  end

  hilo_regs u_regs (
    .clock       (clock),
    .reset       (reset),
    .wsel        (w_wsel),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .cap_q       (div_q),
    .cap_r       (div_r),
    .dz_dividend (op_a),
    .hi          (hi),
    .lo          (lo)
  );

  assign stall        = div_req | (r_state != IDLE);
  assign div_start    = (r_state == START);
  assign div_err      = r_err;
  assign div_rst      = ~reset;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_div_ctrl
// Purpose  : Directed self-checking bench with a behavioural divider core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_div_ctrl;
  import hilo_pkg::*;

  localparam int          DIV_CYCLES = 32;
  localparam logic [31:0] SENTINEL   = 32'h5A5A_5A5A;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        div_req = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        stall, div_err, div_start, div_rst;
  logic        div_busy = 1'b0;
  logic [31:0] div_q = SENTINEL;
  logic [31:0] div_r = SENTINEL;

  logic        core_dead = 1'b0;
  logic        core_pend = 1'b0;
  int          core_cnt  = 0;
  int          errors    = 0;
  int          checks    = 0;

  hilo_div_ctrl #(.DIV_CYCLES(DIV_CYCLES), .TIMEOUT(40)) dut (
    .clock        (clock),
    .reset        (reset),
    .div_req      (div_req),
    .op_a         (op_a),
    .op_b         (op_b),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .wdata        (wdata),
    .hi           (hi),
    .lo           (lo),
    .stall        (stall),
    .div_err      (div_err),
    .div_start    (div_start),
    .div_rst      (div_rst),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  always #5 clock = ~clock;

  // Core model: busy for DIV_CYCLES cycles after start, results one cycle later.
  always @(posedge clock) begin
    if (div_rst) begin
      div_busy  <= 1'b0;
      core_pend <= 1'b0;
      core_cnt  <= 0;
      div_q     <= SENTINEL;
      div_r     <= SENTINEL;
    end else begin
      core_pend <= 1'b0;
      if (div_start && !core_dead) begin
        div_busy <= 1'b1;
        core_cnt <= DIV_CYCLES;
      end else if (div_busy) begin
        if (core_cnt == 1) begin
          div_busy  <= 1'b0;
          core_pend <= 1'b1;
        end
        core_cnt <= core_cnt - 1;
      end
      if (core_pend) begin
        div_q <= $signed(div_dividend) / $signed(div_divisor);
        div_r <= $signed(div_dividend) % $signed(div_divisor);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Runs cycles 0..last of a divide; returns at the start of cycle last+1.
  task automatic div_cycles(input logic [31:0] a, input logic [31:0] b, input int last,
                            input int stall_last, input int mt_cyc, input logic [31:0] hi_hold);
    div_req = 1'b1;
    op_a    = a;
    op_b    = b;
    wdata   = 32'hDEAD_BEEF;
    for (int c = 0; c <= last; c++) begin
      if (c == 1) div_req = 1'b0;
      hi_we = (c == mt_cyc);
      @(negedge clock);
      chk($sformatf("stall_c%0d", c), 32'(stall), 32'(c <= stall_last));
      chk($sformatf("start_c%0d", c), 32'(div_start), 32'(c == 1));
      chk($sformatf("err_c%0d", c), 32'(div_err), 32'd0);
      if (mt_cyc >= 0 && c == mt_cyc + 1) chk("mthi_ignored", hi, hi_hold);
      @(posedge clock);
      #1;
    end
    hi_we = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_divisor", div_divisor, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_err", 32'(div_err), 32'd0);
    chk("rst_div_rst", 32'(div_rst), 32'd1);
    reset = 1'b1;
    tick;
    chk("run_div_rst", 32'(div_rst), 32'd0);

    div_cycles(32'd100, 32'd7, 36, 36, -1, 32'd0);
    chk("q_100_7", lo, 32'd14);
    chk("r_100_7", hi, 32'd2);
    chk("stall_after_100_7", 32'(stall), 32'd0);
    chk("dividend_held", div_dividend, 32'd100);
    chk("divisor_held", div_divisor, 32'd7);

    div_cycles(32'hFFFF_FF9C, 32'd7, 36, 36, 10, 32'd2);
    chk("q_m100_7", lo, 32'hFFFF_FFF2);
    chk("r_m100_7", hi, 32'hFFFF_FFFE);

    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick;
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo, 32'hFFFF_FFF2);

    div_cycles(32'd100, 32'hFFFF_FFF9, 36, 36, -1, 32'd0);
    chk("q_100_m7", lo, 32'hFFFF_FFF2);
    chk("r_100_m7", hi, 32'd2);

    div_req = 1'b1;
    op_a    = 32'd5;
    op_b    = 32'd0;
    @(negedge clock);
    chk("dz_stall_c0", 32'(stall), 32'd1);
    chk("dz_start_c0", 32'(div_start), 32'd0);
    tick;
    div_req = 1'b0;
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    @(negedge clock);
    chk("dz_stall_c1", 32'(stall), 32'd0);
    chk("dz_start_c1", 32'(div_start), 32'd0);
    tick;

    div_cycles(32'd9, 32'd3, 11, 36, -1, 32'd0);
    reset = 1'b0;
    tick;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_div_rst", 32'(div_rst), 32'd1);
    chk("midrst_start", 32'(div_start), 32'd0);
    reset = 1'b1;
    tick;

    div_cycles(32'd9, 32'd3, 36, 36, -1, 32'd0);
    chk("q_9_3", lo, 32'd3);
    chk("r_9_3", hi, 32'd0);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    tick;
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mt_both_hi", hi, 32'h1234_5678);
    chk("mt_both_lo", lo, 32'h1234_5678);

    core_dead = 1'b1;
    div_cycles(32'd50, 32'd5, 40, 40, -1, 32'd0);
    chk("to_err", 32'(div_err), 32'd1);
    chk("to_hi_kept", hi, 32'h1234_5678);
    chk("to_lo_kept", lo, 32'h1234_5678);
    chk("to_stall", 32'(stall), 32'd0);
    tick;
    chk("to_stall_next", 32'(stall), 32'd0);
    chk("to_err_sticky", 32'(div_err), 32'd1);
    core_dead = 1'b0;

    reset = 1'b0;
    tick;
    chk("err_cleared_by_rst", 32'(div_err), 32'd0);
    reset = 1'b1;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
